// File: rtl/picomips_decode_ctrl_pkg.sv
// Shared picoMIPS encoding: widths, opcode values, field positions and control enums.
package picomips_decode_ctrl_pkg;

    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned ADDR_WIDTH = 5;
    localparam int unsigned INST_WIDTH = 6;
    localparam int unsigned INSTR_BITS = INST_WIDTH + 2 * ADDR_WIDTH + DATA_WIDTH;

    // Field positions within the instruction word
    localparam int unsigned OP_MSB  = INSTR_BITS - 1;
    localparam int unsigned OP_LSB  = OP_MSB - INST_WIDTH + 1;
    localparam int unsigned S_MSB   = OP_LSB - 1;
    localparam int unsigned S_LSB   = S_MSB - ADDR_WIDTH + 1;
    localparam int unsigned D_MSB   = S_LSB - 1;
    localparam int unsigned D_LSB   = D_MSB - ADDR_WIDTH + 1;
    localparam int unsigned T_MSB   = ADDR_WIDTH - 1;
    localparam int unsigned IMM_MSB = DATA_WIDTH - 1;

    // Sub-decode bits for NXX and LXX
    localparam int unsigned NXX_SW_BIT  = 16;
    localparam int unsigned NXX_TGT_BIT = 15;
    localparam int unsigned LXX_LED_BIT = 12;
    localparam int unsigned LXX_SEL_BIT = 11;

    typedef enum logic [INST_WIDTH-1:0] {
        OP_ADD = 6'd0,
        OP_ADI = 6'd1,
        OP_MUL = 6'd2,
        OP_MLI = 6'd3,
        OP_NXX = 6'd4,
        OP_LXX = 6'd5
    } opcode_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_IMM = 2'b01,
        WB_SW  = 2'b10
    } wb_sel_e;

    typedef enum logic {
        EXEC    = 1'b0,
        WAIT_SW = 1'b1
    } state_e;

endpackage

// File: rtl/picomips_decode_ctrl_if.sv
// Instruction-in / control-out bundle between program memory, switches and the decoder.
interface picomips_decode_ctrl_if;
    import picomips_decode_ctrl_pkg::*;

    logic [INSTR_BITS-1:0] instr;
    logic                  sw8;
    logic                  pc_en;
    logic [ADDR_WIDTH-1:0] rs_addr;
    logic [ADDR_WIDTH-1:0] rt_addr;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] imm;
    logic                  alu_op;
    logic                  alu_src_imm;
    wb_sel_e               wb_sel;
    logic                  reg_we;
    logic                  led_we;
    logic                  busy;
    logic                  illegal;

    modport master (
        output instr, sw8,
        input  pc_en, rs_addr, rt_addr, rd_addr, imm, alu_op, alu_src_imm,
               wb_sel, reg_we, led_we, busy, illegal
    );

    modport slave (
        input  instr, sw8,
        output pc_en, rs_addr, rt_addr, rd_addr, imm, alu_op, alu_src_imm,
               wb_sel, reg_we, led_we, busy, illegal
    );

endinterface

// File: rtl/picomips_decode_ctrl_sync2.sv
// Generic two-flop synchroniser for asynchronous switch inputs.
module picomips_decode_ctrl_sync2 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two-stage capture; both stages clear on reset
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/picomips_decode_ctrl.sv
// picoMIPS instruction decoder with SW8 handshake sequencer for NSW and LED.
module picomips_decode_ctrl
    import picomips_decode_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    picomips_decode_ctrl_if.slave  bus
);

    logic                  sw8_s;
    state_e                state_q, state_d;
    logic                  target_q, target_d;
    logic                  illegal_q, illegal_d;

    logic [INST_WIDTH-1:0] op;
    logic [ADDR_WIDTH-1:0] s_fld;
    logic [ADDR_WIDTH-1:0] d_fld;
    logic                  hs_req;
    logic                  hs_tgt;

    logic                  pc_en_c;
    logic [ADDR_WIDTH-1:0] rd_c;
    logic                  alu_op_c;
    logic                  src_imm_c;
    wb_sel_e               wb_sel_c;
    logic                  reg_we_c;
    logic                  led_we_c;

    assign op    = bus.instr[OP_MSB:OP_LSB];
    assign s_fld = bus.instr[S_MSB:S_LSB];
    assign d_fld = bus.instr[D_MSB:D_LSB];

    picomips_decode_ctrl_sync2 #(.WIDTH(1)) u_sync_sw8 (
        .clk   (clk),
        .reset (reset),
        .d_i   (bus.sw8),
        .q_o   (sw8_s)
    );

    // State, latched handshake target and sticky illegal flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= EXEC;
            target_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            illegal_q <= illegal_d;
        end
    end

    // Combinational decode and next-state; handshakes compare against synchronised SW8
    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        illegal_d = illegal_q;
        hs_req    = 1'b0;
        hs_tgt    = 1'b0;
        pc_en_c   = 1'b0;
        rd_c      = d_fld;
        alu_op_c  = 1'b0;
        src_imm_c = 1'b0;
        wb_sel_c  = WB_ALU;
        reg_we_c  = 1'b0;
        led_we_c  = 1'b0;

        case (state_q)
            EXEC: begin
                case (op)
                    OP_ADD, OP_ADI, OP_MUL, OP_MLI: begin
                        alu_op_c  = (op == OP_MUL) || (op == OP_MLI);
                        src_imm_c = (op == OP_ADI) || (op == OP_MLI);
                        reg_we_c  = 1'b1;
                        pc_en_c   = 1'b1;
                    end
                    OP_NXX: begin
                        if (bus.instr[NXX_SW_BIT]) begin
                            hs_req = 1'b1;
                            hs_tgt = bus.instr[NXX_TGT_BIT];
                        end else begin
                            pc_en_c = 1'b1;
                        end
                    end
                    OP_LXX: begin
                        rd_c = s_fld;
                        if (bus.instr[LXX_LED_BIT]) begin
                            led_we_c = 1'b1;
                            hs_req   = 1'b1;
                            hs_tgt   = bus.instr[LXX_SEL_BIT];
                        end else begin
                            wb_sel_c = bus.instr[LXX_SEL_BIT] ? WB_SW : WB_IMM;
                            reg_we_c = 1'b1;
                            pc_en_c  = 1'b1;
                        end
                    end
                    default: begin
                        pc_en_c   = 1'b1;
                        illegal_d = 1'b1;
                    end
                endcase

                if (hs_req) begin
                    if (sw8_s == hs_tgt) begin
                        pc_en_c = 1'b1;
                    end else begin
                        target_d = hs_tgt;
                        state_d  = WAIT_SW;
                    end
                end
            end
            WAIT_SW: begin
                if (sw8_s == target_q) begin
                    pc_en_c = 1'b1;
                    state_d = EXEC;
                end
            end
        endcase

        // Nothing advances or writes while reset is held
        if (reset) begin
            pc_en_c  = 1'b0;
            reg_we_c = 1'b0;
            led_we_c = 1'b0;
        end
    end

    assign bus.pc_en       = pc_en_c;
    assign bus.rs_addr     = s_fld;
    assign bus.rt_addr     = bus.instr[T_MSB:0];
    assign bus.rd_addr     = rd_c;
    assign bus.imm         = bus.instr[IMM_MSB:0];
    assign bus.alu_op      = alu_op_c;
    assign bus.alu_src_imm = src_imm_c;
    assign bus.wb_sel      = wb_sel_c;
    assign bus.reg_we      = reg_we_c;
    assign bus.led_we      = led_we_c;
    assign bus.busy        = (state_q == WAIT_SW);
    assign bus.illegal     = illegal_q;

endmodule

// File: tb/tb_picomips_decode_ctrl.sv
// Directed bench for picomips_decode_ctrl: decode table plus handshake/reset sequences.
module tb_picomips_decode_ctrl;
    import picomips_decode_ctrl_pkg::*;

    typedef struct {
        logic [23:0] instr;
        logic        pc_en;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [7:0]  imm;
        logic        alu_op;
        logic        src;
        logic [1:0]  wb;
        logic        reg_we;
        logic        led_we;
    } vec_t;

    logic clk;
    logic reset;
    int   errors;
    int   checks;
    vec_t vecs [9];

    picomips_decode_ctrl_if bus ();

    picomips_decode_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] sig();
        return {1'b0, bus.pc_en, bus.rs_addr, bus.rt_addr, bus.rd_addr, bus.imm,
                bus.alu_op, bus.alu_src_imm, bus.wb_sel, bus.reg_we, bus.led_we, bus.busy};
    endfunction

    function automatic logic [31:0] expsig(input vec_t v);
        return {1'b0, v.pc_en, v.rs, v.rt, v.rd, v.imm,
                v.alu_op, v.src, v.wb, v.reg_we, v.led_we, 1'b0};
    endfunction

    initial begin
        int n;
        errors = 0;
        checks = 0;

        //          instr       pc    rs     rt     rd     imm    aop   src   wb     we    led
        vecs[0] = '{24'h002302, 1'b1, 5'd1, 5'd2, 5'd3, 8'h02, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0}; // ADD
        vecs[1] = '{24'h042305, 1'b1, 5'd1, 5'd5, 5'd3, 8'h05, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0}; // ADI
        vecs[2] = '{24'h084406, 1'b1, 5'd2, 5'd6, 5'd4, 8'h06, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0}; // MUL
        vecs[3] = '{24'h0CE583, 1'b1, 5'd7, 5'd3, 5'd5, 8'h83, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0}; // MLI
        vecs[4] = '{24'h100000, 1'b1, 5'd0, 5'd0, 5'd0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0}; // NOP
        vecs[5] = '{24'h110000, 1'b1, 5'd8, 5'd0, 5'd0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0}; // NSW a=0
        vecs[6] = '{24'h1520A5, 1'b1, 5'd9, 5'd5, 5'd9, 8'hA5, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0}; // LDI
        vecs[7] = '{24'h152800, 1'b1, 5'd9, 5'd0, 5'd9, 8'h00, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0}; // LDS
        vecs[8] = '{24'h147000, 1'b1, 5'd3, 5'd0, 5'd3, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1}; // LED t=0

        // Reset state and forcing of enables
        reset     = 1'b1;
        bus.sw8   = 1'b0;
        bus.instr = 24'h042305;
        tick();
        tick();
        settle();
        chk("rst_pc_en",   32'(bus.pc_en),   32'd0);
        chk("rst_reg_we",  32'(bus.reg_we),  32'd0);
        chk("rst_led_we",  32'(bus.led_we),  32'd0);
        chk("rst_busy",    32'(bus.busy),    32'd0);
        chk("rst_illegal", 32'(bus.illegal), 32'd0);
        reset = 1'b0;
        settle();
        chk("post_rst_pc_en",  32'(bus.pc_en),  32'd1);
        chk("post_rst_reg_we", 32'(bus.reg_we), 32'd1);

        // Single-cycle decode table, EXEC with sw8_s=0
        for (int i = 0; i < 9; i++) begin
            bus.instr = vecs[i].instr;
            settle();
            chk($sformatf("vec%0d", i), sig(), expsig(vecs[i]));
            tick();
        end

        // NSW a=1: stall until synchronised SW8 rises, two-edge latency
        bus.instr = 24'h118000;
        settle();
        chk("nsw1_issue_pc_en", 32'(bus.pc_en), 32'd0);
        chk("nsw1_issue_busy",  32'(bus.busy),  32'd0);
        tick();
        chk("nsw1_wait_busy",   32'(bus.busy),  32'd1);
        chk("nsw1_wait_pc_en",  32'(bus.pc_en), 32'd0);
        tick();
        chk("nsw1_hold_pc_en",  32'(bus.pc_en), 32'd0);
        bus.sw8 = 1'b1;
        tick();
        chk("nsw1_sync1_pc_en", 32'(bus.pc_en), 32'd0);
        tick();
        chk("nsw1_rel_pc_en",   32'(bus.pc_en),  32'd1);
        chk("nsw1_rel_busy",    32'(bus.busy),   32'd1);
        chk("nsw1_rel_reg_we",  32'(bus.reg_we), 32'd0);
        tick();
        chk("nsw1_exec_busy",   32'(bus.busy),  32'd0);
        chk("nsw1_exec_pc_en",  32'(bus.pc_en), 32'd1);

        // NSW a=0 while sw8_s=1: must stall on the latched target 0
        bus.instr = 24'h110000;
        settle();
        chk("nsw0_stall_pc_en", 32'(bus.pc_en), 32'd0);
        tick();
        chk("nsw0_wait_busy",   32'(bus.busy),  32'd1);
        bus.sw8 = 1'b0;
        tick();
        chk("nsw0_sync1_pc_en", 32'(bus.pc_en), 32'd0);
        tick();
        chk("nsw0_rel_pc_en",   32'(bus.pc_en), 32'd1);
        tick();
        chk("nsw0_exec_busy",   32'(bus.busy),  32'd0);

        // LED s=7 t=1: one-cycle led_we, then wait without repeating it
        bus.instr = 24'h14F800;
        settle();
        chk("led_issue_led_we", 32'(bus.led_we),  32'd1);
        chk("led_issue_rs",     32'(bus.rs_addr), 32'd7);
        chk("led_issue_pc_en",  32'(bus.pc_en),   32'd0);
        tick();
        chk("led_wait_led_we",  32'(bus.led_we),  32'd0);
        chk("led_wait_busy",    32'(bus.busy),    32'd1);
        tick();
        chk("led_wait2_led_we", 32'(bus.led_we),  32'd0);
        bus.sw8 = 1'b1;
        n = 0;
        while (bus.pc_en !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        chk("led_release_cycles", 32'(n), 32'd2);
        chk("led_rel_led_we",     32'(bus.led_we), 32'd0);
        tick();
        bus.instr = 24'h100000;
        settle();
        chk("led_exec_busy", 32'(bus.busy), 32'd0);
        bus.sw8 = 1'b0;
        tick();
        tick();
        tick();

        // Illegal opcode acts as NOP and sets a sticky flag
        bus.instr = 24'hFC0000;
        settle();
        chk("ill_pc_en",     32'(bus.pc_en),   32'd1);
        chk("ill_reg_we",    32'(bus.reg_we),  32'd0);
        chk("ill_led_we",    32'(bus.led_we),  32'd0);
        chk("ill_before",    32'(bus.illegal), 32'd0);
        tick();
        chk("ill_set",       32'(bus.illegal), 32'd1);
        bus.instr = 24'h100000;
        tick();
        chk("ill_sticky",    32'(bus.illegal), 32'd1);

        // Reset during a WAIT_SW stall
        bus.instr = 24'h118000;
        tick();
        chk("rstw_busy_before", 32'(bus.busy), 32'd1);
        reset   = 1'b1;
        bus.sw8 = 1'b1;
        settle();
        chk("rstw_pc_en",  32'(bus.pc_en), 32'd0);
        tick();
        chk("rstw_busy",    32'(bus.busy),    32'd0);
        chk("rstw_illegal", 32'(bus.illegal), 32'd0);
        chk("rstw_pc_en_held", 32'(bus.pc_en), 32'd0);
        reset     = 1'b0;
        bus.sw8   = 1'b0;
        bus.instr = 24'h100000;
        settle();
        chk("rstw_nop_pc_en", 32'(bus.pc_en), 32'd1);
        tick();
        chk("rstw_exec_busy", 32'(bus.busy),  32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/picomips_decode_ctrl.md
Name: picomips_decode_ctrl

Overview:
Instruction decoder and control sequencer for the picoMIPS core. It consumes the 24-bit instruction word at the current PC, breaks it into the fields of the shared opcode encoding, and drives register-file, ALU, write-back, LED and PC-advance controls. A two-state FSM implements the SW8 handshake waits of NSW and LED, using an internal 2-flop synchroniser on SW8.

Parameters:
DATA_WIDTH, 8, immediate / datapath width
ADDR_WIDTH, 5, register address width
INST_WIDTH, 6, opcode width
INSTR_BITS, INST_WIDTH+2*ADDR_WIDTH+DATA_WIDTH (24), instruction word width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
instr  in  INSTR_BITS  instruction word from program memory at current PC
sw8  in  1  raw SW8 switch, asynchronous to clk
pc_en  out  1  advance PC at next edge
rs_addr  out  ADDR_WIDTH  source register s
rt_addr  out  ADDR_WIDTH  source register t
rd_addr  out  ADDR_WIDTH  destination register
imm  out  DATA_WIDTH  immediate, instr[7:0]
alu_op  out  1  0=add, 1=multiply
alu_src_imm  out  1  ALU operand B = imm (1) or reg t (0)
wb_sel  out  2  00=ALU, 01=imm, 10=switches
reg_we  out  1  register-file write enable
led_we  out  1  LED register load from rs data
busy  out  1  FSM in WAIT_SW
illegal  out  1  sticky: undefined opcode executed

Behaviour:
- Fields: op=instr[23:18], s=instr[17:13], d=instr[12:8], t=instr[4:0], imm=instr[7:0].
- rs_addr=s and imm=instr[7:0] always. rt_addr=t always.
- rd_addr=d for ADD/ADI/MUL/MLI. rd_addr=s for LXX.
- ADD/MUL: alu_src_imm=0. ADI/MLI: alu_src_imm=1. alu_op=1 for MUL/MLI. wb_sel=00. reg_we=1. pc_en=1.
- NXX: bit16=0 is NOP, pc_en=1. bit16=1 is NSW, target=bit15.
- LXX with bit12=0: bit11=0 is LDI (wb_sel=01); bit11=1 is LDS (wb_sel=10). reg_we=1, pc_en=1.
- LXX with bit12=1 is LED: led_we=1, target=bit11.
- Decode is combinational from instr and FSM state: zero latency in EXEC.
- sw8_s: 2-flop synchroniser, reset 0. Latency from sw8 to sw8_s is 2 edges.
- FSM states: EXEC, WAIT_SW. Reset state is EXEC.
  - EXEC, NSW or LED: if sw8_s==target, pc_en=1 and stay in EXEC. Else pc_en=0, latch target, go to WAIT_SW.
  - LED: led_we=1 only in the EXEC cycle of issue. It never repeats in WAIT_SW.
  - WAIT_SW: all write enables 0, busy=1. While sw8_s!=target, pc_en=0. When sw8_s==target, pc_en=1 that cycle and return to EXEC.
  - instr is stable while in WAIT_SW because the PC is held. The latched target is used, not instr.
- Illegal op (>5): behaves as NOP (pc_en=1, no writes). illegal is set the next edge and held until reset.
- Reset (any state, including mid-wait): next edge gives state=EXEC, sw8_s=0, illegal=0.
  - While reset is high, pc_en, reg_we and led_we are forced 0.
- No arithmetic in this block. Widths pass through unchanged.

Decomposition:
- Shared package gets:
  - opcode enum and width parameters (existing)
  - field-position localparams: OP_MSB, S_MSB, D_MSB, T_MSB, bit positions 16/15/12/11
  - wb_sel enum (WB_ALU, WB_IMM, WB_SW)
  - FSM state enum (EXEC, WAIT_SW)
- One natural sub-module: sync2 (generic 2-flop synchroniser, synchronous active-high reset), reused later for other switches.

Test Plan:
- ADI r3=r1+5: instr=0x042305, EXEC -> rs=1, rd=3, imm=0x05, alu_src_imm=1, alu_op=0, wb_sel=00, reg_we=1, pc_en=1, busy=0.
- NSW a=1: instr=0x118000 with sw8=0 -> pc_en=0, busy=1 from next edge. Raise sw8 at edge k -> pc_en=1 in the cycle after edge k+2, then busy=0.
- NSW a=0: instr=0x110000 with sw8 already 0 and synchronised -> pc_en=1 the same cycle, never busy.
- LED s=7 t=1: instr=0x14F800, sw8=0 -> led_we=1 for exactly one cycle, rs=7. Then busy=1 and led_we=0 until sw8_s=1.
- LDS r9: instr=0x152800 -> rd=9, wb_sel=10, reg_we=1, pc_en=1. LDI r9,0xA5 (0x1520A5) -> wb_sel=01, imm=0xA5.
- Illegal: instr=0xFC0000 -> reg_we=0, pc_en=1, illegal=1 from next edge and sticky. Then assert reset during a WAIT_SW stall -> pc_en=0 during reset, then EXEC, busy=0, illegal=0.
